// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
//   Bundles the instruction handshake, datapath status and control strobes of the
//   multi-cycle LEGv8 controller.
//   master: fetch stage / datapath side (drives instruction, status flags)
//   slave : controller side (drives instrReady, control strobes, register addresses)
//   Signals:
//     instrValid, instruction, instrReady        instruction handshake
//     aluZero, memDone                           datapath status
//     unconditionalBranch, branch, pcWrite,
//     memRead, memWrite, memToReg, aluOp,
//     aluSRC, regWrite                           control strobes
//     readRegister1/2, writeRegister             register-file addresses
//     illegal                                    sticky fault flag
interface multicycle_controller_if #(
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  instrValid;
    logic                  instrReady;
    logic [INSTR_W-1:0]    instruction;
    logic                  aluZero;
    logic                  memDone;
    logic                  unconditionalBranch;
    logic                  branch;
    logic                  pcWrite;
    logic                  memRead;
    logic                  memWrite;
    logic                  memToReg;
    logic [1:0]            aluOp;
    logic                  aluSRC;
    logic                  regWrite;
    logic [REG_ADDR_W-1:0] readRegister1;
    logic [REG_ADDR_W-1:0] readRegister2;
    logic [REG_ADDR_W-1:0] writeRegister;
    logic                  illegal;

    modport master (
        output instrValid, instruction, aluZero, memDone,
        input  instrReady, unconditionalBranch, branch, pcWrite, memRead, memWrite,
               memToReg, aluOp, aluSRC, regWrite, readRegister1, readRegister2,
               writeRegister, illegal
    );

    modport slave (
        input  instrValid, instruction, aluZero, memDone,
        output instrReady, unconditionalBranch, branch, pcWrite, memRead, memWrite,
               memToReg, aluOp, aluSRC, regWrite, readRegister1, readRegister2,
               writeRegister, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle LEGv8 control unit. Latches one instruction per valid/ready handshake and
//   walks FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK), issuing control strobes.
//   Ports:
//     clock  in  rising-edge clock
//     reset  in  synchronous, active-high
//     bus    slave modport of multicycle_controller_if (handshake, status, strobes,
//            register addresses, sticky illegal flag)
module multicycle_controller #(
    parameter int unsigned INSTR_W     = 32,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic                   clock,
    input logic                   reset,
    multicycle_controller_if.slave bus
);
    localparam int unsigned   CntW       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(MEM_TIMEOUT);

    typedef enum logic [2:0] {StFetch, StDecode, StExecute, StMemory, StWriteback} state_e;
    typedef enum logic [2:0] {ClsIllegal, ClsLdur, ClsStur, ClsRtype, ClsCbz, ClsB} class_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               illegal_q, illegal_d;
    logic [10:0]        opcode;
    class_e             cls;
    logic               reg2loc;
    logic               busy;
    logic               unused_bits;

    assign opcode = instr_q[INSTR_W-1 -: 11];

    // Opcode classification from the latched word; stable for the whole instruction.
    always_comb begin
        cls = ClsIllegal;
        if (opcode == 11'h7C2) begin
            cls = ClsLdur;
        end else if (opcode == 11'h7C0) begin
            cls = ClsStur;
        end else if (opcode inside {11'h458, 11'h658, 11'h450, 11'h550}) begin
            cls = ClsRtype;
        end else if (opcode[10:3] == 8'hB4) begin
            cls = ClsCbz;
        end else if (opcode[10:5] == 6'h05) begin
            cls = ClsB;
        end
    end

    assign reg2loc = (cls == ClsStur) || (cls == ClsCbz);
    assign busy    = (state_q != StFetch);

    // Addresses are held at zero while idle so FETCH shows no stale fields.
    assign bus.readRegister1 = busy ? REG_ADDR_W'(instr_q[9:5]) : '0;
    assign bus.readRegister2 = !busy ? '0 :
                               reg2loc ? REG_ADDR_W'(instr_q[4:0]) : REG_ADDR_W'(instr_q[20:16]);
    assign bus.writeRegister = busy ? REG_ADDR_W'(instr_q[4:0]) : '0;
    assign bus.illegal       = illegal_q;

    // Immediate/shift fields and the zero flag belong to the datapath.
    assign unused_bits = ^{instr_q[15:10], bus.aluZero};

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;

        bus.instrReady          = 1'b0;
        bus.unconditionalBranch = 1'b0;
        bus.branch              = 1'b0;
        bus.pcWrite             = 1'b0;
        bus.memRead             = 1'b0;
        bus.memWrite            = 1'b0;
        bus.memToReg            = 1'b0;
        bus.aluOp               = 2'b00;
        bus.aluSRC              = 1'b0;
        bus.regWrite            = 1'b0;

        // ALU controls are held from EXECUTE until the instruction retires.
        if (state_q inside {StExecute, StMemory, StWriteback}) begin
            unique case (cls)
                ClsLdur, ClsStur: begin
                    bus.aluOp  = 2'b00;
                    bus.aluSRC = 1'b1;
                end
                ClsRtype: bus.aluOp = 2'b10;
                ClsCbz:   bus.aluOp = 2'b01;
                default:  ;
            endcase
        end

        unique case (state_q)
            StFetch: begin
                bus.instrReady = 1'b1;
                if (bus.instrValid) begin
                    instr_d = bus.instruction;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (cls == ClsIllegal) begin
                    illegal_d = 1'b1;
                    state_d   = StFetch;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                unique case (cls)
                    ClsB: begin
                        bus.unconditionalBranch = 1'b1;
                        bus.pcWrite             = 1'b1;
                        state_d                 = StFetch;
                    end
                    ClsCbz: begin
                        bus.branch  = 1'b1;
                        bus.pcWrite = 1'b1;
                        state_d     = StFetch;
                    end
                    ClsLdur, ClsStur: begin
                        cnt_d   = '0;
                        state_d = StMemory;
                    end
                    ClsRtype: state_d = StWriteback;
                    default:  state_d = StFetch;
                endcase
            end
            StMemory: begin
                // Counter saturates at the timeout value; that cycle drops the strobes.
                if (cnt_q == TimeoutCnt) begin
                    illegal_d = 1'b1;
                    state_d   = StFetch;
                end else begin
                    bus.memRead  = (cls == ClsLdur);
                    bus.memWrite = (cls == ClsStur);
                    cnt_d        = cnt_q + 1'b1;
                    if (bus.memDone) begin
                        if (cls == ClsStur) begin
                            bus.pcWrite = 1'b1;
                            state_d     = StFetch;
                        end else begin
                            state_d = StWriteback;
                        end
                    end
                end
            end
            StWriteback: begin
                bus.regWrite = 1'b1;
                bus.pcWrite  = 1'b1;
                bus.memToReg = (cls == ClsLdur);
                state_d      = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // A reset cycle must not let any side-effecting strobe escape.
        if (reset) begin
            bus.unconditionalBranch = 1'b0;
            bus.branch              = 1'b0;
            bus.pcWrite             = 1'b0;
            bus.memRead             = 1'b0;
            bus.memWrite            = 1'b0;
            bus.regWrite            = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StFetch;
            instr_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end
endmodule
